ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device receiver for the SCPU IOBUS keyboard port. It synchronises and deglitches the raw `PS2_clk`/`PS2_Data` pins and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). Accepted scan codes go into a first-word-fall-through FIFO that the CPU drains through the IOBUS. It replaces single-byte keyboard capture with buffered, error-flagged, timeout-protected reception.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 50000: idle clk cycles mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `rd_en` in 1: pop the FIFO head this cycle.
- `clr_err` in 1: clear all sticky error flags.
- `data` out 8: FIFO head; valid when `valid`=1.
- `valid` out 1: FIFO not empty.
- `count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; a good frame was dropped because the FIFO was full.
- `parity_err` out 1: sticky; a frame failed odd parity.
- `frame_err` out 1: sticky; the stop bit sampled 0.

## Operation
- Input path:
  - Both pins pass through a 2-flop synchroniser.
  - `ps2_clk` is then filtered: the filtered level flips only after `FILTER_LEN` consecutive samples at the new level.
  - A falling edge of the filtered clock produces a 1-cycle `fall` strobe.
  - `ps2_data` is sampled on `fall`, using the synchronised value delayed to match the filter delay.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA and set `bit_cnt`=0. On data=1, stay in IDLE and drop the bit as a spurious start.
  - DATA: on `fall`, shift the bit into `shreg[7]` (right shift) and increment `bit_cnt`. After 8 bits, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE and apply the first matching rule:
    - parity bad (XOR of 8 data bits and parity bit ≠ 1): set `parity_err`, drop the byte.
    - stop bit = 0: set `frame_err`, drop the byte.
    - FIFO full and no simultaneous pop: set `overflow`, drop the byte.
    - otherwise: push `shreg`.
- Timeout:
  - A counter runs in every non-IDLE state and is reset by each `fall`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE and the partial frame is discarded silently, with no flag.
- FIFO:
  - Data is first-word-fall-through, so `data` shows the head combinationally from registered storage.
  - `rd_en` while empty is ignored.
  - Push and pop in the same cycle are both honoured, including when full, leaving `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Errors:
  - `clr_err` clears all three sticky flags.
  - If `clr_err` coincides with a new error event, the flag stays set.
- Reset:
  - `rst_n` low at any time returns the FSM to IDLE, empties the FIFO, clears all flags and counters, and sets synchroniser and filter state to 1 (bus idle).
  - A frame in progress at reset is lost.

## Timing
- Output reset values: `data`=0, `valid`=0, `count`=0, `overflow`=0, `parity_err`=0, `frame_err`=0.
- Latency from the raw `ps2_clk` falling at the stop bit to `valid`/`count` updating: exactly `FILTER_LEN`+4 clk cycles. This covers 2 synchroniser cycles, `FILTER_LEN` filter cycles, 1 cycle for the edge strobe and 1 cycle for the push.
- Error flags are set on the same cycle the push would have occurred.
- Pop: `rd_en` at cycle N updates `data`, `count` and `valid` at N+1.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (`ps2_state_t`);
  - frame constants (`PS2_DATA_BITS`=8, `PS2_FRAME_BITS`=11);
  - function `odd_parity_ok(data, par)`.
- Sub-module `sync_fifo` holds parameters `WIDTH` and `DEPTH`, the FWFT storage and the full/empty/count logic. It is instantiated once with `WIDTH`=8.
- Synchroniser, filter, FSM and timeout counter stay in the top module.

## Test plan
- Send 0x1C with parity 0 and stop 1 → after the last edge + `FILTER_LEN`+4 cycles: `valid`=1, `data`=0x1C, `count`=1; pulse `rd_en` → `valid`=0.
- Send 0x1C with parity 1 → `parity_err`=1, `count`=0. Pulse `clr_err` → `parity_err`=0. Send 0xF0 with stop=0 → `frame_err`=1, `count`=0.
- With `FIFO_DEPTH`=4, send 0x01..0x05 without reads → `count`=4, `overflow`=1. Reads return 0x01..0x04 in order. Also cover a push and a pop in the same cycle while full → `count` stays 4 and no overflow.
- Send a start bit plus 3 data bits, hold the bus idle for `TIMEOUT_CYCLES`+10, then send 0x5A → FIFO holds only 0x5A and no flags are set.
- Inject a 2-cycle low glitch on `ps2_clk` in the middle of a 0x29 frame with `FILTER_LEN`=4 → 0x29 is received intact.
- Assert `rst_n`=0 midway through a frame while the FIFO holds 2 bytes → all outputs are zero. After release, a full 0x1C frame yields `count`=1 and `data`=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types, frame constants and parity helper.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic par);
        return ^{d, par};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head visible combinationally from registered storage.
// Push/pop take effect on the next edge; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && valid;
    assign do_wr   = wr_en && (!full || do_rd);
    // Gated so the head reads zero whenever nothing is queued, including after reset.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device receiver: sync + deglitch pins, deframe 11-bit frames, queue bytes in a FWFT FIFO.
// Stop-bit fall to valid is FILTER_LEN+4 cycles; full FIFO drops frames and raises sticky overflow.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    data,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BCW = $clog2(PS2_FRAME_BITS);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FCW-1:0]        filt_cnt;
    logic                  filt_clk;
    logic                  filt_d;
    logic                  fall;
    logic [FILTER_LEN:0]   dat_dly;
    logic                  bit_in;

    ps2_state_t            state;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                  par_bit;
    logic [BCW-1:0]        bit_cnt;
    logic [TCW-1:0]        to_cnt;
    logic                  timeout;

    logic                  fifo_full;
    logic                  frame_done;
    logic                  par_ok;
    logic                  par_evt;
    logic                  frm_evt;
    logic                  ovf_evt;
    logic                  push;

    // Data is delayed by the filter depth plus the strobe stage so the sample lines up with fall.
    assign bit_in = dat_dly[FILTER_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_cnt <= '0;
            filt_clk <= 1'b1;
            filt_d   <= 1'b1;
            fall     <= 1'b0;
            dat_dly  <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            dat_dly  <= {dat_dly[FILTER_LEN-1:0], dat_sync[1]};
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
            filt_d <= filt_clk;
            fall   <= filt_d & ~filt_clk;
        end
    end

    assign timeout    = (state != ST_IDLE) && (to_cnt == TCW'(TIMEOUT_CYCLES));
    assign frame_done = (state == ST_STOP) && fall;
    assign par_ok     = odd_parity_ok(shreg, par_bit);
    assign par_evt    = frame_done && !par_ok;
    assign frm_evt    = frame_done && par_ok && !bit_in;
    assign ovf_evt    = frame_done && par_ok && bit_in && fifo_full && !rd_en;
    assign push       = frame_done && par_ok && bit_in && !(fifo_full && !rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state == ST_IDLE || fall)
                to_cnt <= '0;
            else if (!timeout)
                to_cnt <= to_cnt + 1'b1;

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {bit_in, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BCW'(PS2_DATA_BITS - 1))
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= bit_in;
                        state   <= ST_STOP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state <= ST_IDLE;
            end
        end
    end

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= ovf_evt | (overflow   & ~clr_err);
            parity_err <= par_evt | (parity_err & ~clr_err);
            frame_err  <= frm_evt | (frame_err  & ~clr_err);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (data),
        .valid   (valid),
        .full    (fifo_full),
        .count   (count)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are driven bit by bit on the raw pins.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 4;
    localparam int FLEN  = 4;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .data       (data),
        .valid      (valid),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Drives n bits; the last one may be left with the clock low so callers can time the push.
    task automatic drive_bits(input logic [10:0] fr, input int n, input int glitch_bit, input bit leave_low);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            if (i == glitch_bit) begin
                cyc(HALF / 2);
                ps2_clk = 1'b0;
                cyc(2);
                ps2_clk = 1'b1;
                cyc(HALF - HALF / 2 - 2);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (leave_low && i == n - 1) return;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic end_frame();
        cyc(HALF);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit stop, input int glitch_bit);
        drive_bits(mk_frame(b, bad_par, stop), PS2_FRAME_BITS, glitch_bit, 1'b1);
        end_frame();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if ({overflow, parity_err, frame_err} !== 3'b000)
            begin errors++; $display("FAIL reset_flags: got %b exp 000", {overflow, parity_err, frame_err}); end
        rst_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_single();
        drive_bits(mk_frame(8'h1C, 1'b0, 1'b1), PS2_FRAME_BITS, -1, 1'b1);
        cyc(FLEN + 3);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL latency_early: count %0d exp 0", count); end
        cyc(1);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL latency_count: got %0d exp 1", count); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", valid); end
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL single_data: got %h exp 1c", data); end
        end_frame();
        pop();
        checks++; if ({valid, count} !== 4'b0_000)
            begin errors++; $display("FAIL single_pop: valid %b count %0d exp 0 0", valid, count); end
    endtask

    task automatic test_errors();
        send_byte(8'h1C, 1'b1, 1'b1, -1);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_set: got %b exp 1", parity_err); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL parity_drop: count %0d exp 0", count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL parity_frame: got %b exp 0", frame_err); end
        clear_flags();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clr: got %b exp 0", parity_err); end
        send_byte(8'hF0, 1'b0, 1'b0, -1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_set: got %b exp 1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL frame_par: got %b exp 0", parity_err); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL frame_drop: count %0d exp 0", count); end
        clear_flags();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b0, 1'b1, -1);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        checks++; if (data !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h exp 01", data); end
        clear_flags();
        // Pop exactly on the push edge while full.
        drive_bits(mk_frame(8'h06, 1'b0, 1'b1), PS2_FRAME_BITS, -1, 1'b1);
        cyc(FLEN + 3);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_count: got %0d exp 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf: got %b exp 0", overflow); end
        end_frame();
        for (int i = 0; i < 4; i++) begin
            checks++; if (data !== exp_q[i])
                begin errors++; $display("FAIL ovf_read%0d: got %h exp %h", i, data, exp_q[i]); end
            pop();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid %b exp 0", valid); end
    endtask

    task automatic test_timeout();
        drive_bits(mk_frame(8'hA5, 1'b0, 1'b1), 4, -1, 1'b0);
        cyc(TMO + 10);
        send_byte(8'h5A, 1'b0, 1'b1, -1);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL tmo_count: got %0d exp 1", count); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL tmo_data: got %h exp 5a", data); end
        checks++; if ({overflow, parity_err, frame_err} !== 3'b000)
            begin errors++; $display("FAIL tmo_flags: got %b exp 000", {overflow, parity_err, frame_err}); end
        pop();
    endtask

    task automatic test_glitch();
        send_byte(8'h29, 1'b0, 1'b1, 4);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL glitch_count: got %0d exp 1", count); end
        checks++; if (data !== 8'h29) begin errors++; $display("FAIL glitch_data: got %h exp 29", data); end
        checks++; if ({overflow, parity_err, frame_err} !== 3'b000)
            begin errors++; $display("FAIL glitch_flags: got %b exp 000", {overflow, parity_err, frame_err}); end
        pop();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11, 1'b0, 1'b1, -1);
        send_byte(8'h22, 1'b0, 1'b1, -1);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d exp 2", count); end
        drive_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if ({valid, count, data} !== 12'h000)
            begin errors++; $display("FAIL rst_mid_out: valid %b count %0d data %h exp all 0", valid, count, data); end
        checks++; if ({overflow, parity_err, frame_err} !== 3'b000)
            begin errors++; $display("FAIL rst_mid_flags: got %b exp 000", {overflow, parity_err, frame_err}); end
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        send_byte(8'h1C, 1'b0, 1'b1, -1);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rst_post_count: got %0d exp 1", count); end
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL rst_post_data: got %h exp 1c", data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_overflow();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
